pc_sequencer: RTL and testbench

- Parametrised program-counter sequencer for the mini processor core.
- Generalises the fixed 4-bit free-running PC. Adds:
  - configurable width and reset vector;
  - stall and halt/resume control;
  - absolute jump and PC-relative branch;
  - call/return through a hardware return-address stack.
- Sits between the decoder/control unit and the instruction-memory address port.

---
 rtl/pc_sequencer.sv | 104 ++++++++++
 tb/tb_pc_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: reset vector, stall, halt/resume, jump,
// PC-relative branch and call/return through a small hardware return stack.
module pc_sequencer #(
  parameter int              PC_W        = 8,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            halt,
  input  logic            resume,
  input  logic            stall,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_addr,
  input  logic            branch,
  input  logic [PC_W-1:0] branch_off,
  input  logic            call,
  input  logic            ret,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            stk_empty,
  output logic            stk_full,
  output logic            stk_err
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t          state;
  logic [CNT_W-1:0] count;
  logic [PC_W-1:0]  stack [STACK_DEPTH];
  logic [PC_W-1:0]  pc_inc;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] push_idx;

  // Next sequential address and stack pointers derived from the occupancy count
  always_comb begin
    pc_inc   = pc + PC_W'(1);
    top_idx  = IDX_W'(count - CNT_W'(1));
    push_idx = IDX_W'(count);
  end

  assign halted    = (state == HALTED);
  assign stk_empty = (count == '0);
  assign stk_full  = (count == CNT_W'(STACK_DEPTH));

  // Run/halt FSM plus prioritised PC update and return-stack push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      pc      <= RESET_PC;
      count   <= '0;
      stk_err <= 1'b0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
        stack[i] <= '0;
      end
    end else begin
      case (state)
        RUN: begin
          if (halt) begin
            state <= HALTED;
          end else if (stall) begin
            pc <= pc;
          end else if (ret) begin
            if (!stk_empty) begin
              pc    <= stack[top_idx];
              count <= count - CNT_W'(1);
            end else begin
              stk_err <= 1'b1;
              pc      <= pc_inc;
            end
          end else if (call) begin
            if (!stk_full) begin
              stack[push_idx] <= pc_inc;
              count           <= count + CNT_W'(1);
              pc              <= jump_addr;
            end else begin
              stk_err <= 1'b1;
              pc      <= pc_inc;
            end
          end else if (jump) begin
            pc <= jump_addr;
          end else if (branch) begin
            pc <= pc + branch_off;
          end else begin
            pc <= pc_inc;
          end
        end
        HALTED: begin
          if (resume) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios followed by random
// traffic, all predicted by a queue-based reference model.
module tb_pc_sequencer;

  localparam logic [7:0] C_IDLE  = 8'h00;
  localparam logic [7:0] C_RST   = 8'h80;
  localparam logic [7:0] C_HALT  = 8'h40;
  localparam logic [7:0] C_RES   = 8'h20;
  localparam logic [7:0] C_STALL = 8'h10;
  localparam logic [7:0] C_RET   = 8'h08;
  localparam logic [7:0] C_CALL  = 8'h04;
  localparam logic [7:0] C_JUMP  = 8'h02;
  localparam logic [7:0] C_BR    = 8'h01;

  logic       clk;
  logic       rst, halt, resume, stall, jump, branch, call, ret;
  logic [7:0] jump_addr, branch_off;
  logic [7:0] pc;
  logic       halted, stk_empty, stk_full, stk_err;

  pc_sequencer #(
    .PC_W(8),
    .RESET_PC(8'h10),
    .STACK_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst), .halt(halt), .resume(resume), .stall(stall),
    .jump(jump), .jump_addr(jump_addr), .branch(branch), .branch_off(branch_off),
    .call(call), .ret(ret), .pc(pc), .halted(halted), .stk_empty(stk_empty),
    .stk_full(stk_full), .stk_err(stk_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic [7:0] m_pc;
  bit         m_halted;
  bit         m_err;
  logic [7:0] m_stk[$];

  logic [11:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic model_step(input logic [7:0] c, input logic [7:0] ja, input logic [7:0] off);
    if (c[7]) begin
      m_pc = 8'h10; m_halted = 0; m_err = 0; m_stk.delete();
    end else if (m_halted) begin
      if (c[5]) m_halted = 0;
    end else if (c[6]) begin
      m_halted = 1;
    end else if (c[4]) begin
      // hold
    end else if (c[3]) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin m_err = 1; m_pc = m_pc + 8'd1; end
    end else if (c[2]) begin
      if (m_stk.size() < 2) begin m_stk.push_back(m_pc + 8'd1); m_pc = ja; end
      else begin m_err = 1; m_pc = m_pc + 8'd1; end
    end else if (c[1]) begin
      m_pc = ja;
    end else if (c[0]) begin
      m_pc = m_pc + off;
    end else begin
      m_pc = m_pc + 8'd1;
    end
  endtask

  task automatic drive(input logic [7:0] c, input logic [7:0] ja, input logic [7:0] off);
    @(negedge clk);
    rst = c[7]; halt = c[6]; resume = c[5]; stall = c[4];
    ret = c[3]; call = c[2]; jump = c[1]; branch = c[0];
    jump_addr = ja; branch_off = off;
    model_step(c, ja, off);
    exp_q.push_back({m_pc, m_halted, m_stk.size() == 0, m_stk.size() == 2, m_err});
  endtask

  // Monitor: every cycle the DUT presents a new state; check it against the queue
  initial begin : monitor
    logic [11:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {pc, halted, stk_empty, stk_full, stk_err};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL state_check t=%0t pc=%h want %h halted=%b want %b empty=%b want %b full=%b want %b err=%b want %b",
                   $time, a[11:4], e[11:4], a[3], e[3], a[2], e[2], a[1], e[1], a[0], e[0]);
        end
      end
    end
  end

  initial begin : stimulus
    logic [7:0] c;
    rst = 1; halt = 0; resume = 0; stall = 0; jump = 0; branch = 0;
    call = 0; ret = 0; jump_addr = '0; branch_off = '0;
    m_pc = 8'h10; m_halted = 0; m_err = 0;

    // 1: reset, count, wrap through all-ones
    drive(C_RST, 8'h00, 8'h00);
    repeat (3) drive(C_IDLE, 8'h00, 8'h00);
    drive(C_JUMP, 8'hFF, 8'h00);
    drive(C_IDLE, 8'h00, 8'h00);
    // 2: stall then jump-beats-branch
    drive(C_JUMP, 8'h20, 8'h00);
    drive(C_STALL, 8'h00, 8'h00);
    drive(C_STALL, 8'h00, 8'h00);
    drive(C_IDLE, 8'h00, 8'h00);
    drive(C_JUMP | C_BR, 8'h40, 8'h05);
    // 3: backward branches, including wrap through zero
    drive(C_BR, 8'h00, 8'hFC);
    drive(C_JUMP, 8'h02, 8'h00);
    drive(C_BR, 8'h00, 8'hFC);
    // 4: call/return with overflow and underflow
    drive(C_JUMP, 8'h30, 8'h00);
    drive(C_CALL, 8'h80, 8'h00);
    drive(C_CALL, 8'h90, 8'h00);
    drive(C_CALL, 8'hA0, 8'h00);
    drive(C_RET, 8'h00, 8'h00);
    drive(C_RET, 8'h00, 8'h00);
    drive(C_RET, 8'h00, 8'h00);
    // 5: halt ignores other controls, resume, reset while halted
    drive(C_JUMP, 8'h50, 8'h00);
    drive(C_HALT, 8'h00, 8'h00);
    repeat (4) drive(C_JUMP | C_CALL | C_HALT, 8'h77, 8'h00);
    drive(C_RES, 8'h00, 8'h00);
    drive(C_IDLE, 8'h00, 8'h00);
    drive(C_RES | C_BR, 8'h00, 8'h08);
    drive(C_HALT, 8'h00, 8'h00);
    drive(C_RST, 8'h00, 8'h00);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      c = C_IDLE;
      if ($urandom_range(63) == 0) c |= C_RST;
      if ($urandom_range(15) == 0) c |= C_HALT;
      if ($urandom_range(3) == 0)  c |= C_RES;
      if ($urandom_range(7) == 0)  c |= C_STALL;
      if ($urandom_range(4) == 0)  c |= C_RET;
      if ($urandom_range(4) == 0)  c |= C_CALL;
      if ($urandom_range(5) == 0)  c |= C_JUMP;
      if ($urandom_range(3) == 0)  c |= C_BR;
      drive(c, 8'($urandom), 8'($urandom));
    end

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
